// File: rtl/memory_port_arbiter_pkg.sv
// Shared types and defaults for the IC/DC main-memory port arbiter.
package mem_arb_pkg;

  localparam int DEFAULT_ADDR_W      = 32;
  localparam int DEFAULT_DATA_W      = 32;
  localparam int DEFAULT_MEM_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } requester_t;

  function automatic requester_t other_side(input requester_t r);
    requester_t o;
    case (r)
      REQ_IC:  o = REQ_DC;
      REQ_DC:  o = REQ_IC;
      default: o = REQ_IC;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/memory_port_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and the memory model.
interface memory_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              ic_req;
  logic              ic_we;
  logic [ADDR_W-1:0] ic_addr;
  logic [DATA_W-1:0] ic_wdata;
  logic              ic_ack;
  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_ack;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  // Arbiter side.
  modport slave (
    input  ic_req, ic_we, ic_addr, ic_wdata,
    input  dc_req, dc_we, dc_addr, dc_wdata,
    input  mem_rdata,
    output ic_ack, dc_ack, rdata,
    output mem_addr, mem_wdata, mem_we, busy
  );

  // Requester and memory-model side.
  modport master (
    output ic_req, ic_we, ic_addr, ic_wdata,
    output dc_req, dc_we, dc_addr, dc_wdata,
    output mem_rdata,
    input  ic_ack, dc_ack, rdata,
    input  mem_addr, mem_wdata, mem_we, busy
  );

endinterface

// File: rtl/memory_port_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin grant; on a tie the side not granted last wins.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       ic_req,
  input  logic       dc_req,
  input  requester_t last_grant,
  output logic       grant_valid,
  output requester_t grant
);

  // Pick the winner among the currently asserted requests.
  always_comb begin
    grant_valid = ic_req | dc_req;
    grant       = REQ_IC;
    if (ic_req && dc_req) begin
      grant = other_side(last_grant);
    end else if (dc_req) begin
      grant = REQ_DC;
    end else begin
      grant = REQ_IC;
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares the single-ported main memory between IC refills and DC writebacks/refills,
// one word transaction at a time with a fixed memory latency.
module memory_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  memory_port_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  arb_state_t        state_r;
  requester_t        last_grant_r;
  requester_t        owner_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              mem_we_r;
  logic [DATA_W-1:0] rdata_r;
  logic              ic_ack_r;
  logic              dc_ack_r;
  logic              busy_r;

  logic              grant_valid_s;
  requester_t        grant_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  rr_arbiter2 u_rr (
    .ic_req      (bus.ic_req),
    .dc_req      (bus.dc_req),
    .last_grant  (last_grant_r),
    .grant_valid (grant_valid_s),
    .grant       (grant_s)
  );

  // Route the winning requester's transaction fields toward the latches.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = {ADDR_W{1'b0}};
    sel_wdata_s = {DATA_W{1'b0}};
    if (grant_s == REQ_DC) begin
      sel_we_s    = bus.dc_we;
      sel_addr_s  = bus.dc_addr;
      sel_wdata_s = bus.dc_wdata;
    end else begin
      sel_we_s    = bus.ic_we;
      sel_addr_s  = bus.ic_addr;
      sel_wdata_s = bus.ic_wdata;
    end
  end

  // Transaction FSM: grant in IDLE, hold the memory port for MEM_LATENCY cycles, then ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= REQ_IC;
      owner_r      <= REQ_IC;
      cnt_r        <= {CNT_W{1'b0}};
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
      mem_we_r     <= 1'b0;
      rdata_r      <= {DATA_W{1'b0}};
      ic_ack_r     <= 1'b0;
      dc_ack_r     <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ic_ack_r <= 1'b0;
          dc_ack_r <= 1'b0;
          if (grant_valid_s) begin
            owner_r      <= grant_s;
            last_grant_r <= grant_s;
            mem_addr_r   <= sel_addr_s;
            mem_wdata_r  <= sel_wdata_s;
            mem_we_r     <= sel_we_s;
            cnt_r        <= CNT_W'(MEM_LATENCY - 1);
            busy_r       <= 1'b1;
            state_r      <= ACCESS;
          end else begin
            mem_we_r <= 1'b0;
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end
        end
        ACCESS: begin
          // The write strobe only lasts the first ACCESS cycle.
          mem_we_r <= 1'b0;
          if (cnt_r == {CNT_W{1'b0}}) begin
            rdata_r  <= bus.mem_rdata;
            ic_ack_r <= (owner_r == REQ_IC);
            dc_ack_r <= (owner_r == REQ_DC);
            state_r  <= ACK;
          end else begin
            cnt_r   <= cnt_r - CNT_W'(1);
            state_r <= ACCESS;
          end
        end
        ACK: begin
          ic_ack_r <= 1'b0;
          dc_ack_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          ic_ack_r <= 1'b0;
          dc_ack_r <= 1'b0;
          mem_we_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.ic_ack    = ic_ack_r;
  assign bus.dc_ack    = dc_ack_r;
  assign bus.rdata     = rdata_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed self-checking bench for memory_port_arbiter with a small word memory model.
module tb_memory_port_arbiter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [31:0] mem [0:255];

  memory_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  memory_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: asynchronous read, write on the clock edge while mem_we is high.
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.ic_ack !== 1'b0) begin n_err++; $display("FAIL reset_ic_ack got %b want 0", bus.ic_ack); end
    n_vec++; if (bus.dc_ack !== 1'b0) begin n_err++; $display("FAIL reset_dc_ack got %b want 0", bus.dc_ack); end
    n_vec++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", bus.rdata); end
    n_vec++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
    n_vec++; if (bus.mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dc_read;
    bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 32'h40;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n <= 4) begin
        n_vec++; if (bus.mem_addr !== 32'h40) begin n_err++; $display("FAIL dc_read_mem_addr cycle %0d got %h want 00000040", n, bus.mem_addr); end
      end
      n_vec++; if (bus.dc_ack !== (n == 5)) begin n_err++; $display("FAIL dc_read_dc_ack cycle %0d got %b want %b", n, bus.dc_ack, (n == 5)); end
      n_vec++; if (bus.ic_ack !== 1'b0) begin n_err++; $display("FAIL dc_read_ic_ack cycle %0d got %b want 0", n, bus.ic_ack); end
      if (n == 5) begin
        n_vec++; if (bus.rdata !== 32'h11223344) begin n_err++; $display("FAIL dc_read_rdata got %h want 11223344", bus.rdata); end
        bus.dc_req = 1'b0;
      end
      if (n == 6) begin
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL dc_read_idle_busy got %b want 0", bus.busy); end
      end
    end
  endtask

  task automatic test_write_readback;
    bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_addr = 32'h80; bus.dc_wdata = 32'hDEADBEEF;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n <= 5) begin
        n_vec++; if (bus.mem_we !== (n == 1)) begin n_err++; $display("FAIL wr_mem_we cycle %0d got %b want %b", n, bus.mem_we, (n == 1)); end
        n_vec++; if (bus.dc_ack !== (n == 5)) begin n_err++; $display("FAIL wr_dc_ack cycle %0d got %b want %b", n, bus.dc_ack, (n == 5)); end
      end
      if (n == 5) begin bus.dc_req = 1'b0; bus.dc_we = 1'b0; end
    end
    bus.ic_req = 1'b1; bus.ic_we = 1'b0; bus.ic_addr = 32'h80;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n <= 5) begin
        n_vec++; if (bus.ic_ack !== (n == 5)) begin n_err++; $display("FAIL rb_ic_ack cycle %0d got %b want %b", n, bus.ic_ack, (n == 5)); end
      end
      if (n == 5) begin
        n_vec++; if (bus.rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rb_rdata got %h want deadbeef", bus.rdata); end
        bus.ic_req = 1'b0;
      end
    end
  endtask

  task automatic test_tie_after_reset;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.ic_req = 1'b1; bus.ic_we = 1'b0; bus.ic_addr = 32'h40;
    bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 32'h80;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      n_vec++; if (bus.dc_ack !== (n == 5)) begin n_err++; $display("FAIL tie_dc_ack cycle %0d got %b want %b", n, bus.dc_ack, (n == 5)); end
      n_vec++; if (bus.ic_ack !== (n == 11)) begin n_err++; $display("FAIL tie_ic_ack cycle %0d got %b want %b", n, bus.ic_ack, (n == 11)); end
      if (n == 2) begin
        n_vec++; if (bus.mem_addr !== 32'h80) begin n_err++; $display("FAIL tie_first_addr got %h want 00000080", bus.mem_addr); end
      end
      if (n == 7) begin
        n_vec++; if (bus.mem_addr !== 32'h40) begin n_err++; $display("FAIL tie_second_addr got %h want 00000040", bus.mem_addr); end
      end
      if (n == 5) bus.dc_req = 1'b0;
      if (n == 11) begin
        n_vec++; if (bus.rdata !== 32'h11223344) begin n_err++; $display("FAIL tie_ic_rdata got %h want 11223344", bus.rdata); end
        bus.ic_req = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back;
    int k;
    logic want_dc;
    k = 0;
    bus.ic_req = 1'b1; bus.ic_we = 1'b0; bus.ic_addr = 32'h40;
    bus.dc_req = 1'b1; bus.dc_we = 1'b0; bus.dc_addr = 32'h80;
    for (int cyc = 1; cyc <= 60 && k < 6; cyc++) begin
      @(negedge clk);
      if (bus.ic_ack && bus.dc_ack) begin
        n_vec++; n_err++; $display("FAIL b2b_double_ack cycle %0d got both want one", cyc);
      end
      if (bus.ic_ack || bus.dc_ack) begin
        want_dc = (k % 2 == 0);
        n_vec++; if (bus.dc_ack !== want_dc) begin n_err++; $display("FAIL b2b_order ack %0d got dc_ack=%b want %b", k, bus.dc_ack, want_dc); end
        n_vec++; if (cyc !== 5 + 6 * k) begin n_err++; $display("FAIL b2b_timing ack %0d got cycle %0d want %0d", k, cyc, 5 + 6 * k); end
        k++;
      end
    end
    bus.ic_req = 1'b0; bus.dc_req = 1'b0;
    n_vec++; if (k !== 6) begin n_err++; $display("FAIL b2b_count got %0d acks want 6", k); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access;
    bus.dc_req = 1'b1; bus.dc_we = 1'b1; bus.dc_addr = 32'h100; bus.dc_wdata = 32'hCAFEF00D;
    @(negedge clk);
    n_vec++; if (bus.mem_we !== 1'b1) begin n_err++; $display("FAIL rstmid_mem_we_first got %b want 1", bus.mem_we); end
    @(negedge clk);
    rst = 1'b1; bus.dc_req = 1'b0; bus.dc_we = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL rstmid_mem_we got %b want 0", bus.mem_we); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL rstmid_mem_addr got %h want 0", bus.mem_addr); end
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      n_vec++; if (bus.dc_ack !== 1'b0) begin n_err++; $display("FAIL rstmid_no_dc_ack step %0d got %b want 0", n, bus.dc_ack); end
      @(negedge clk);
    end
    bus.ic_req = 1'b1; bus.ic_we = 1'b0; bus.ic_addr = 32'h40;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      n_vec++; if (bus.ic_ack !== (n == 5)) begin n_err++; $display("FAIL rstmid_ic_ack cycle %0d got %b want %b", n, bus.ic_ack, (n == 5)); end
      if (n == 5) begin
        n_vec++; if (bus.rdata !== 32'h11223344) begin n_err++; $display("FAIL rstmid_ic_rdata got %h want 11223344", bus.rdata); end
        bus.ic_req = 1'b0;
      end
    end
  endtask

  task automatic test_early_drop;
    bus.ic_req = 1'b1; bus.ic_we = 1'b0; bus.ic_addr = 32'h40;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) bus.ic_req = 1'b0;
      n_vec++; if (bus.ic_ack !== (n == 5)) begin n_err++; $display("FAIL drop_ic_ack cycle %0d got %b want %b", n, bus.ic_ack, (n == 5)); end
      n_vec++; if (bus.dc_ack !== 1'b0) begin n_err++; $display("FAIL drop_dc_ack cycle %0d got %b want 0", n, bus.dc_ack); end
      if (n >= 6) begin
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL drop_regrant cycle %0d busy got %b want 0", n, bus.busy); end
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1;
    bus.ic_req = 1'b0; bus.ic_we = 1'b0; bus.ic_addr = 32'h0; bus.ic_wdata = 32'h0;
    bus.dc_req = 1'b0; bus.dc_we = 1'b0; bus.dc_addr = 32'h0; bus.dc_wdata = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[16] = 32'h11223344;
    test_reset();
    test_dc_read();
    test_write_readback();
    test_tie_after_reset();
    test_back_to_back();
    test_reset_mid_access();
    test_early_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
